// File: rtl/preemph_sweep_if.sv
// Control/status bundle between the pre-emphasis sweep sequencer and its host.
// The master side drives sweep requests, configuration and checker pulses.
// The slave side (the sequencer) returns taps, status and sweep results.
interface preemph_sweep_if #(
  parameter int TAP_W   = 3,
  parameter int DWELL_W = 16,
  parameter int ERR_W   = 16
);
  logic               start;
  logic               abort;
  logic [TAP_W-1:0]   tap_min;
  logic [TAP_W-1:0]   tap_max;
  logic [DWELL_W-1:0] dwell;
  logic               err_in;
  logic [TAP_W-1:0]   taps;
  logic               lfsr_rst;
  logic               busy;
  logic               done;
  logic               cfg_err;
  logic [TAP_W-1:0]   best_tap;
  logic [ERR_W-1:0]   best_err;

  modport master (
    output start, abort, tap_min, tap_max, dwell, err_in,
    input  taps, lfsr_rst, busy, done, cfg_err, best_tap, best_err
  );

  modport slave (
    input  start, abort, tap_min, tap_max, dwell, err_in,
    output taps, lfsr_rst, busy, done, cfg_err, best_tap, best_err
  );
endinterface

// File: rtl/preemph_sweep_ctrl.sv
// Pre-emphasis taps sweep sequencer.
// For each setting in [tap_min, tap_max]: pulse lfsr_rst, wait SETTLE cycles,
// count checker errors for max(dwell,1) cycles, then keep the setting if it is
// strictly better than the best so far. At the end the best setting is applied.
// Every output comes straight from a flop; the 1-bit status flops are loaded
// from the next state so that they line up with the state they describe.
module preemph_sweep_ctrl #(
  parameter int TAP_W   = 3,
  parameter int DWELL_W = 16,
  parameter int ERR_W   = 16,
  parameter int SETTLE  = 8
) (
  input  logic           clk,
  input  logic           reset,
  preemph_sweep_if.slave sw
);

  // Settle counter holds SETTLE-1 down to 0.
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_MEASURE,
    ST_COMPARE,
    ST_DONE
  } state_t;

  state_t             state_q,      state_d;
  logic [TAP_W-1:0]   tap_max_q,    tap_max_d;
  logic [DWELL_W-1:0] meas_len_q,   meas_len_d;   // max(dwell,1)-1
  logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [DWELL_W-1:0] meas_cnt_q,   meas_cnt_d;
  logic [ERR_W-1:0]   err_cnt_q,    err_cnt_d;
  logic [TAP_W-1:0]   taps_q,       taps_d;
  logic [TAP_W-1:0]   best_tap_q,   best_tap_d;
  logic [ERR_W-1:0]   best_err_q,   best_err_d;
  logic               lfsr_rst_q,   lfsr_rst_d;
  logic               busy_q,       busy_d;
  logic               done_q,       done_d;
  logic               cfg_err_q,    cfg_err_d;

  // Next-state and datapath updates; everything holds unless a state acts on it.
  always_comb begin
    state_d      = state_q;
    tap_max_d    = tap_max_q;
    meas_len_d   = meas_len_q;
    settle_cnt_d = settle_cnt_q;
    meas_cnt_d   = meas_cnt_q;
    err_cnt_d    = err_cnt_q;
    taps_d       = taps_q;
    best_tap_d   = best_tap_q;
    best_err_d   = best_err_q;
    cfg_err_d    = 1'b0;

    if (sw.abort && (state_q != ST_IDLE)) begin
      // Abandon the sweep; taps and best_* keep their partial values.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // abort in the same cycle suppresses both a sweep and cfg_err
          if (sw.start && !sw.abort) begin
            if (sw.tap_min <= sw.tap_max) begin
              tap_max_d  = sw.tap_max;
              meas_len_d = (sw.dwell == '0) ? '0 : sw.dwell - DWELL_W'(1);
              taps_d     = sw.tap_min;
              best_tap_d = sw.tap_min;
              best_err_d = '1;
              state_d    = ST_LOAD;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end

        ST_LOAD: begin
          err_cnt_d    = '0;
          settle_cnt_d = SET_W'(SETTLE - 1);
          state_d      = ST_SETTLE;
        end

        ST_SETTLE: begin
          // err_in is deliberately not looked at while the link settles
          if (settle_cnt_q == '0) begin
            meas_cnt_d = meas_len_q;
            state_d    = ST_MEASURE;
          end else begin
            settle_cnt_d = settle_cnt_q - SET_W'(1);
          end
        end

        ST_MEASURE: begin
          if (sw.err_in && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
          end
          if (meas_cnt_q == '0) begin
            state_d = ST_COMPARE;
          end else begin
            meas_cnt_d = meas_cnt_q - DWELL_W'(1);
          end
        end

        ST_COMPARE: begin
          // strict compare: on a tie the earlier (lower) setting is kept
          if (err_cnt_q < best_err_q) begin
            best_err_d = err_cnt_q;
            best_tap_d = taps_q;
          end
          // stopping at tap_max means taps never wraps past its top value
          if (taps_q == tap_max_q) begin
            state_d = ST_DONE;
          end else begin
            taps_d  = taps_q + TAP_W'(1);
            state_d = ST_LOAD;
          end
        end

        ST_DONE: begin
          taps_d  = best_tap_q;
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Status flags are registered copies of the state being entered.
    busy_d     = (state_d != ST_IDLE);
    lfsr_rst_d = (state_d == ST_LOAD);
    done_d     = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tap_max_q    <= '0;
      meas_len_q   <= '0;
      settle_cnt_q <= '0;
      meas_cnt_q   <= '0;
      err_cnt_q    <= '0;
      taps_q       <= '0;
      best_tap_q   <= '0;
      best_err_q   <= '1;
      lfsr_rst_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tap_max_q    <= tap_max_d;
      meas_len_q   <= meas_len_d;
      settle_cnt_q <= settle_cnt_d;
      meas_cnt_q   <= meas_cnt_d;
      err_cnt_q    <= err_cnt_d;
      taps_q       <= taps_d;
      best_tap_q   <= best_tap_d;
      best_err_q   <= best_err_d;
      lfsr_rst_q   <= lfsr_rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign sw.taps     = taps_q;
  assign sw.lfsr_rst = lfsr_rst_q;
  assign sw.busy     = busy_q;
  assign sw.done     = done_q;
  assign sw.cfg_err  = cfg_err_q;
  assign sw.best_tap = best_tap_q;
  assign sw.best_err = best_err_q;

endmodule

// File: tb/tb_preemph_sweep_ctrl.sv
// Bench for preemph_sweep_ctrl: directed table of sweeps, hand-written abort /
// reset sequences, and randomized sweeps checked against a window-count model.
// Sample index e means "just after clock edge e", edge 0 being the edge that
// samples start. Setting k then occupies e in [k*P, k*P+P-1], P=SETTLE+D+2,
// its measure window is e in [k*P+1+SETTLE, k*P+SETTLE+D], done is seen at N*P.
module tb_preemph_sweep_ctrl;
  localparam int TAP_W   = 3;
  localparam int DWELL_W = 16;
  localparam int ERR_W   = 4;
  localparam int SETTLE  = 8;
  localparam int ERR_MAX = (1 << ERR_W) - 1;
  localparam int MAXC    = 1024;

  localparam int K_NONE   = 0;  // no errors
  localparam int K_CNT    = 1;  // c0..c3 errors at the start of each measure window
  localparam int K_SETTLE = 2;  // errors everywhere except the measure windows
  localparam int K_ALL    = 3;  // errors on every cycle
  localparam int K_RAND   = 4;  // random errors, density c0 (0..3 quarters)

  typedef struct {
    int tmin;
    int tmax;
    int dwell;
    int kind;
    int c0;
    int c1;
    int c2;
    int c3;
    int exp_tap;
    int exp_err;
    bit bad;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  preemph_sweep_if #(.TAP_W(TAP_W), .DWELL_W(DWELL_W), .ERR_W(ERR_W)) sw ();

  preemph_sweep_ctrl #(
    .TAP_W(TAP_W), .DWELL_W(DWELL_W), .ERR_W(ERR_W), .SETTLE(SETTLE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sw   (sw)
  );

  int n_vec = 0;
  int n_err = 0;
  int idle_taps = 0;   // taps value expected while idle
  bit sched[MAXC];
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int dwell_eff(input int dw);
    return (dw == 0) ? 1 : dw;
  endfunction

  // Error schedule indexed by sample index.
  task automatic build_sched(input vec_t v);
    int d, p, n, k, r, c;
    d = dwell_eff(v.dwell);
    p = SETTLE + d + 2;
    n = v.tmax - v.tmin + 1;
    for (int i = 0; i < MAXC; i++) sched[i] = 1'b0;
    for (int i = 0; i < n * p + 2; i++) begin
      k = i / p;
      r = i % p;
      case (v.kind)
        K_SETTLE: sched[i] = !((k < n) && (r >= 1 + SETTLE) && (r <= SETTLE + d));
        K_ALL:    sched[i] = 1'b1;
        K_RAND:   sched[i] = ($urandom_range(0, 3) < v.c0);
        default:  sched[i] = 1'b0;
      endcase
    end
    if (v.kind == K_CNT) begin
      for (int kk = 0; kk < n && kk < 4; kk++) begin
        c = (kk == 0) ? v.c0 : (kk == 1) ? v.c1 : (kk == 2) ? v.c2 : v.c3;
        for (int j = 0; j < c; j++) sched[kk * p + 1 + SETTLE + j] = 1'b1;
      end
    end
  endtask

  // Reference: count errors falling in each measure window, saturate, keep strict minimum.
  task automatic model(input int tmin, input int tmax, input int dw, output int bt, output int be);
    int d, p, cnt;
    d  = dwell_eff(dw);
    p  = SETTLE + d + 2;
    be = ERR_MAX;
    bt = tmin;
    for (int k = 0; k <= tmax - tmin; k++) begin
      cnt = 0;
      for (int j = 0; j < d; j++) cnt += int'(sched[k * p + 1 + SETTLE + j]);
      if (cnt > ERR_MAX) cnt = ERR_MAX;
      if (cnt < be) begin
        be = cnt;
        bt = tmin + k;
      end
    end
  endtask

  // Runs one sweep from idle (called #1 after an edge) and checks every cycle.
  task automatic run_sweep(input vec_t v, input bit noisy);
    int d, p, n, exp_taps;
    d = dwell_eff(v.dwell);
    p = SETTLE + d + 2;
    n = v.tmax - v.tmin + 1;
    sw.tap_min = TAP_W'(v.tmin);
    sw.tap_max = TAP_W'(v.tmax);
    sw.dwell   = DWELL_W'(v.dwell);
    sw.start   = 1'b1;
    sw.err_in  = 1'b0;
    step();
    sw.start   = 1'b0;
    sw.tap_min = TAP_W'($urandom);
    sw.tap_max = TAP_W'($urandom);
    sw.dwell   = DWELL_W'($urandom_range(0, 3));
    if (v.bad) begin
      chk("cfg_err_pulse", 32'(sw.cfg_err), 1);
      chk("bad_busy", 32'(sw.busy), 0);
      chk("bad_taps", 32'(sw.taps), idle_taps);
      step();
      chk("cfg_err_1cyc", 32'(sw.cfg_err), 0);
      chk("bad_busy2", 32'(sw.busy), 0);
      $display("sweep min=%0d max=%0d rejected, cfg_err=1", v.tmin, v.tmax);
      return;
    end
    for (int e = 0; e <= n * p + 1; e++) begin
      if (e <= n * p) begin
        exp_taps = (e < n * p) ? v.tmin + e / p : v.tmax;
        chk("busy", 32'(sw.busy), 1);
        chk("lfsr_rst", 32'(sw.lfsr_rst), ((e % p == 0) && (e < n * p)) ? 1 : 0);
        chk("done", 32'(sw.done), (e == n * p) ? 1 : 0);
        chk("taps", 32'(sw.taps), exp_taps);
        chk("cfg_err", 32'(sw.cfg_err), 0);
        if (e == 0) begin
          chk("init_best_tap", 32'(sw.best_tap), v.tmin);
          chk("init_best_err", 32'(sw.best_err), ERR_MAX);
        end
        sw.err_in = sched[e];
        if (noisy) begin
          sw.start   = (e < n * p) && ($urandom_range(0, 15) == 0);
          sw.tap_min = TAP_W'($urandom);
          sw.tap_max = TAP_W'($urandom);
        end
        step();
      end else begin
        sw.err_in = 1'b0;
        sw.start  = 1'b0;
        chk("busy_end", 32'(sw.busy), 0);
        chk("done_end", 32'(sw.done), 0);
        chk("lfsr_end", 32'(sw.lfsr_rst), 0);
        chk("taps_final", 32'(sw.taps), v.exp_tap);
        chk("best_tap", 32'(sw.best_tap), v.exp_tap);
        chk("best_err", 32'(sw.best_err), v.exp_err);
      end
    end
    idle_taps = v.exp_tap;
    $display("sweep min=%0d max=%0d dwell=%0d -> best_tap=%0d best_err=%0d",
             v.tmin, v.tmax, v.dwell, sw.best_tap, sw.best_err);
  endtask

  initial begin
    vec_t v;
    int bt, be;

    //          tmin tmax dwell kind      c0 c1 c2 c3 tap err bad
    tbl[0] = '{0, 3, 10, K_NONE,   0, 0, 0, 0, 0, 0,  1'b0};
    tbl[1] = '{2, 5, 16, K_CNT,    5, 2, 2, 7, 3, 2,  1'b0};
    tbl[2] = '{6, 1, 10, K_NONE,   0, 0, 0, 0, 0, 0,  1'b1};
    tbl[3] = '{0, 2, 5,  K_SETTLE, 0, 0, 0, 0, 0, 0,  1'b0};
    tbl[4] = '{1, 3, 0,  K_ALL,    0, 0, 0, 0, 1, 1,  1'b0};
    tbl[5] = '{7, 7, 25, K_CNT,   20, 0, 0, 0, 7, 15, 1'b0};

    reset = 1'b1;
    sw.start = 1'b0; sw.abort = 1'b0; sw.err_in = 1'b0;
    sw.tap_min = '0; sw.tap_max = '0; sw.dwell = '0;
    repeat (3) step();
    chk("rst_taps", 32'(sw.taps), 0);
    chk("rst_best_tap", 32'(sw.best_tap), 0);
    chk("rst_best_err", 32'(sw.best_err), ERR_MAX);
    chk("rst_busy", 32'(sw.busy), 0);
    chk("rst_done", 32'(sw.done), 0);
    chk("rst_lfsr", 32'(sw.lfsr_rst), 0);
    chk("rst_cfg_err", 32'(sw.cfg_err), 0);
    reset = 1'b0;
    step();

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      build_sched(tbl[i]);
      run_sweep(tbl[i], 1'b0);
      step();
    end

    // Abort during the second MEASURE of a 0..7 sweep (index 32, window 29..38).
    v = '{0, 7, 10, K_NONE, 0, 0, 0, 0, 0, 0, 1'b0};
    build_sched(v);
    sw.tap_min = 3'd0; sw.tap_max = 3'd7; sw.dwell = 16'd10; sw.start = 1'b1;
    step();
    sw.start = 1'b0;
    for (int e = 0; e < 32; e++) begin
      chk("abort_pre_busy", 32'(sw.busy), 1);
      step();
    end
    chk("abort_pre_taps", 32'(sw.taps), 1);
    sw.abort = 1'b1;
    step();
    sw.abort = 1'b0;
    chk("abort_busy", 32'(sw.busy), 0);
    chk("abort_taps", 32'(sw.taps), 1);
    chk("abort_lfsr", 32'(sw.lfsr_rst), 0);
    for (int e = 0; e < 30; e++) begin
      chk("abort_no_done", 32'(sw.done), 0);
      chk("abort_idle_busy", 32'(sw.busy), 0);
      step();
    end
    chk("abort_keep_taps", 32'(sw.taps), 1);
    chk("abort_best_tap", 32'(sw.best_tap), 0);
    chk("abort_best_err", 32'(sw.best_err), 0);
    $display("abort at setting 1 -> taps=%0d busy=%0d", sw.taps, sw.busy);
    idle_taps = 1;
    v = '{0, 7, 3, K_NONE, 0, 0, 0, 0, 0, 0, 1'b0};
    build_sched(v);
    run_sweep(v, 1'b0);
    step();

    // abort and start in the same idle cycle: no sweep.
    sw.tap_min = 3'd0; sw.tap_max = 3'd3; sw.dwell = 16'd4;
    sw.start = 1'b1; sw.abort = 1'b1;
    step();
    sw.start = 1'b0; sw.abort = 1'b0;
    chk("abst_busy", 32'(sw.busy), 0);
    chk("abst_cfg_err", 32'(sw.cfg_err), 0);
    step();
    chk("abst_busy2", 32'(sw.busy), 0);
    chk("abst_taps", 32'(sw.taps), idle_taps);
    $display("abort+start together -> busy=%0d", sw.busy);

    // Randomized sweeps against the model, with config/start noise mid-sweep.
    for (int r = 0; r < 16; r++) begin
      v.tmin  = $urandom_range(0, 7);
      v.tmax  = $urandom_range(v.tmin, 7);
      v.dwell = $urandom_range(0, 30);
      v.kind  = K_RAND;
      v.c0    = $urandom_range(0, 3);
      v.c1 = 0; v.c2 = 0; v.c3 = 0;
      v.bad   = 1'b0;
      build_sched(v);
      model(v.tmin, v.tmax, v.dwell, bt, be);
      v.exp_tap = bt;
      v.exp_err = be;
      run_sweep(v, 1'b1);
      step();
    end

    // Reset in the middle of a sweep.
    sw.tap_min = 3'd2; sw.tap_max = 3'd5; sw.dwell = 16'd10; sw.start = 1'b1;
    step();
    sw.start = 1'b0;
    for (int e = 0; e < 50; e++) begin
      sw.err_in = (e % 3 == 0);
      step();
    end
    sw.err_in = 1'b0;
    chk("mid_busy", 32'(sw.busy), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_taps", 32'(sw.taps), 0);
    chk("mrst_best_err", 32'(sw.best_err), ERR_MAX);
    chk("mrst_best_tap", 32'(sw.best_tap), 0);
    chk("mrst_busy", 32'(sw.busy), 0);
    chk("mrst_lfsr", 32'(sw.lfsr_rst), 0);
    step();
    chk("mrst_stay_idle", 32'(sw.busy), 0);
    idle_taps = 0;
    $display("reset mid-sweep -> taps=%0d best_err=%0d", sw.taps, sw.best_err);

    // Single top setting after reset: one setting only, saturating count.
    build_sched(tbl[5]);
    run_sweep(tbl[5], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
